// File: rtl/output_1_sched.sv
`default_nettype none
// ============================================================================
// Module      : output_1_sched
// Description : Frame sequencer for the binarized output layer. Accepts one
//               feature vector per time step, drives the weight-ROM address,
//               registers the vector so it lines up with the ROM read data,
//               and collects the step-tagged datapath results into a small
//               credit-protected FIFO.
//               Optional feature macro: OUTPUT_1_SCHED_PERF_EN (frame cycle
//               counter on perf_cycles; tied to 0 when undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module output_1_sched #(
  parameter int STEPS      = 32,
  parameter int IN_W       = 480,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             rom_en,
  output logic [4:0]       rom_addr,
  output logic [IN_W-1:0]  dp_data,
  output logic             dp_valid,
  input  logic [OUT_W-1:0] dp_result,
  input  logic             dp_result_valid,
  output logic [OUT_W-1:0] res_data,
  output logic [4:0]       res_step,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [15:0]      perf_cycles
);

  localparam int               c_AW    = $clog2(FIFO_DEPTH);
  localparam int               c_CW    = c_AW + 1;
  localparam logic [c_CW-1:0]  c_FULL  = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW:0]    c_CRED  = (c_CW+1)'(FIFO_DEPTH);
  localparam logic [4:0]       c_LAST  = 5'(STEPS-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_step;
  logic [4:0]        r_tag1, r_tag2;
  logic [c_CW-1:0]   r_inflight, w_infl_nxt;
  logic [c_CW-1:0]   r_count, w_cnt_nxt;
  logic [c_AW-1:0]   r_wptr, r_rptr;
  logic [OUT_W-1:0]  r_mem_d [FIFO_DEPTH];
  logic [4:0]        r_mem_s [FIFO_DEPTH];

  logic              w_start_ok, w_acc, w_pop, w_push, w_full;
  logic              w_bad_infl, w_bad_full, w_res_ok;
  logic [c_CW:0]     w_used;

  // Handshake, credit and FIFO control decode
  always_comb begin
    w_start_ok = start && (r_state == S_IDLE || r_state == S_DONE);
    w_used     = {1'b0, r_count} + {1'b0, r_inflight};
    in_ready   = (r_state == S_RUN) && (w_used < c_CRED);
    w_acc      = in_ready && in_valid;
    rom_en     = w_acc;
    rom_addr   = r_step;
    res_valid  = (r_count != '0);
    res_data   = r_mem_d[r_rptr];
    res_step   = r_mem_s[r_rptr];
    w_pop      = res_valid && res_ready;
    w_full     = (r_count == c_FULL);
    w_bad_infl = dp_result_valid && (r_inflight == '0);
    w_bad_full = dp_result_valid && w_full;
    w_res_ok   = dp_result_valid && !w_bad_infl;
    w_push     = w_res_ok && !w_bad_full;
    w_infl_nxt = r_inflight;
    if (w_acc && !w_res_ok)      w_infl_nxt = r_inflight + c_CW'(1);
    else if (!w_acc && w_res_ok) w_infl_nxt = r_inflight - c_CW'(1);
    w_cnt_nxt  = r_count;
    if (w_push && !w_pop)        w_cnt_nxt = r_count + c_CW'(1);
    else if (!w_push && w_pop)   w_cnt_nxt = r_count - c_CW'(1);
  end

  // Next-state and status outputs; DRAIN exits as the last result leaves
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_acc && r_step == c_LAST) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_infl_nxt == '0 && w_cnt_nxt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Step counter, ROM-aligned data stage, tag pipeline, credits, FIFO, error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step     <= '0;
      dp_data    <= '0;
      dp_valid   <= 1'b0;
      r_tag1     <= '0;
      r_tag2     <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      err        <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_d[i] <= '0;
        r_mem_s[i] <= '0;
      end
    end else begin
      if (w_start_ok)                    r_step <= '0;
      else if (w_acc && r_step != c_LAST) r_step <= r_step + 5'd1;
      dp_valid <= w_acc;
      if (w_acc) begin
        dp_data <= in_data;
        r_tag1  <= r_step;
      end
      r_tag2     <= r_tag1;
      r_inflight <= w_infl_nxt;
      r_count    <= w_cnt_nxt;
      if (w_push) begin
        r_mem_d[r_wptr] <= dp_result;
        r_mem_s[r_wptr] <= r_tag2;
        r_wptr          <= r_wptr + c_AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + c_AW'(1);
      if (w_bad_infl || w_bad_full) err <= 1'b1;
    end
  end

`ifdef OUTPUT_1_SCHED_PERF_EN
  logic [15:0] r_perf;

  // Frame cycle counter: cleared on start, counts RUN/DRAIN, saturates
  always_ff @(posedge clk) begin
    if (!rst_n)                          r_perf <= '0;
    else if (w_start_ok)                 r_perf <= '0;
    else if (busy && r_perf != 16'hFFFF) r_perf <= r_perf + 16'd1;
  end

  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule
`default_nettype wire
